// File: rtl/rx_word_align_pkg.sv
// Shared types and defaults for the lane word aligner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the aligner FSM state encoding, the default training word / lock
// criteria, and a small helper for sizing counters.
package rx_word_align_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BIT = 3'd1,
    SETTLE   = 3'd2,
    CHECK    = 3'd3,
    SLIP     = 3'd4,
    LOCKED   = 3'd5,
    FAIL     = 3'd6
  } state_t;

  localparam int         DEF_DATA_WIDTH    = 8;
  localparam logic [7:0] DEF_TRAIN_PATTERN = 8'hB8;
  localparam int         DEF_MATCH_CNT     = 16;
  localparam int         DEF_SETTLE_CYCLES = 4;
  localparam int         DEF_TIMEOUT_WIDTH = 16;

  // Bits needed to hold the value max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rx_word_align_cmp.sv
// Training-word comparator with consecutive-match counter.
// Latency: 1 cycle from rx_data to match_done / mismatch.
// Backpressure: none; evaluates every cycle while clr is low.
//
// Ports:
//   sclk, resetn      lane clock, async active-low reset
//   clr               holds counter and flags at zero (aligner not checking)
//   rx_data           deserialised word under test
//   match_done        MATCH_CNT consecutive matches have been seen
//   mismatch          the last sampled word differed from the pattern
module rx_word_align_cmp
  import rx_word_align_pkg::*;
#(
  parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int                    MATCH_CNT     = DEF_MATCH_CNT
) (
  input  logic                  sclk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  match_done,
  output logic                  mismatch
);

  localparam int CW = cnt_width(MATCH_CNT);

  logic [CW-1:0] match_cnt;

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      match_cnt  <= '0;
      match_done <= 1'b0;
      mismatch   <= 1'b0;
    end else if (clr) begin
      match_cnt  <= '0;
      match_done <= 1'b0;
      mismatch   <= 1'b0;
    end else if (rx_data == TRAIN_PATTERN) begin
      // Counter saturates at MATCH_CNT so it can never wrap while the
      // aligner takes its extra cycle to act on match_done.
      if (match_cnt != CW'(MATCH_CNT)) begin
        match_cnt <= match_cnt + 1'b1;
      end
      match_done <= (match_cnt >= CW'(MATCH_CNT - 1));
      mismatch   <= 1'b0;
    end else begin
      match_cnt  <= '0;
      match_done <= 1'b0;
      mismatch   <= 1'b1;
    end
  end

endmodule

// File: rtl/rx_word_align.sv
// Word aligner: slips the deserialiser until the training word locks.
// Latency: RX_WORD_OUT is RX_DATA delayed 1 cycle; status outputs registered.
// Backpressure: none; RX_WORD_VALID qualifies the stream once locked.
//
// Ports:
//   SCLK, RESETN            lane clock, async active-low reset
//   PLL_LOCK                PLL locked; low forces the aligner back to IDLE
//   BIT_ALGN_DONE/_ERR      status from the bit aligner upstream
//   RX_DATA                 deserialiser word
//   WORD_ALGN_RSTRT         restart pulse, overrides everything
//   BITSLIP                 one-cycle slip request to the IOD
//   WORD_ALGN_DONE/_ERR     locked / gave up (mutually exclusive)
//   SLIP_POS                slips applied so far (final value once locked)
//   RX_WORD_OUT/_VALID      registered data and lock qualifier
//
// Build option: define WORD_ALIGN_TIMEOUT_EN to add a TIMEOUT_WIDTH-bit
// watchdog that fails the alignment if it stalls before lock.
module rx_word_align
  import rx_word_align_pkg::*;
#(
  parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int                    MATCH_CNT     = DEF_MATCH_CNT,
  parameter int                    SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int                    TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
  input  logic                          SCLK,
  input  logic                          RESETN,
  input  logic                          PLL_LOCK,
  input  logic                          BIT_ALGN_DONE,
  input  logic                          BIT_ALGN_ERR,
  input  logic [DATA_WIDTH-1:0]         RX_DATA,
  input  logic                          WORD_ALGN_RSTRT,
  output logic                          BITSLIP,
  output logic                          WORD_ALGN_DONE,
  output logic                          WORD_ALGN_ERR,
  output logic [$clog2(DATA_WIDTH)-1:0] SLIP_POS,
  output logic [DATA_WIDTH-1:0]         RX_WORD_OUT,
  output logic                          RX_WORD_VALID
);

  localparam int SPW = $clog2(DATA_WIDTH);
  // One bit wider than SLIP_POS: the count must be able to reach DATA_WIDTH.
  localparam int SCW = cnt_width(DATA_WIDTH);
  localparam int STW = cnt_width(SETTLE_CYCLES);

  state_t           state;
  logic [SCW-1:0]   slip_cnt;
  logic [STW-1:0]   settle_cnt;
  logic             cmp_clr;
  logic             match_done;
  logic             mismatch;
  logic             bad_drop;
  logic             wdog_expired;

  // Losing bit alignment after it was achieved sends us back to wait for it.
  assign bad_drop = !BIT_ALGN_DONE && (state inside {SETTLE, CHECK, SLIP, LOCKED});

  // The comparator only accumulates while checking; everywhere else it is
  // held clear so stale results from before a slip never leak into CHECK.
  assign cmp_clr = (state != CHECK);

  rx_word_align_cmp #(
    .DATA_WIDTH    (DATA_WIDTH),
    .TRAIN_PATTERN (TRAIN_PATTERN),
    .MATCH_CNT     (MATCH_CNT)
  ) u_cmp (
    .sclk       (SCLK),
    .resetn     (RESETN),
    .clr        (cmp_clr),
    .rx_data    (RX_DATA),
    .match_done (match_done),
    .mismatch   (mismatch)
  );

`ifdef WORD_ALIGN_TIMEOUT_EN
  // Fires as the counter steps into all-ones.
  localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LAST = ~(TIMEOUT_WIDTH'(1));

  logic [TIMEOUT_WIDTH-1:0] wdog;
  logic                     wdog_active;

  assign wdog_active  = state inside {WAIT_BIT, SETTLE, CHECK, SLIP};
  assign wdog_expired = wdog_active && (wdog == WDOG_LAST);

  // Zero in IDLE/LOCKED/FAIL, so every entry to WAIT_BIT (from IDLE or on
  // a bit-alignment drop) and every lock starts the count afresh.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      wdog <= '0;
    end else if (WORD_ALGN_RSTRT || !PLL_LOCK || bad_drop || !wdog_active) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 1'b1;
    end
  end
`else
  // No watchdog: the parameter is kept for a uniform interface only.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_WIDTH;
  assign wdog_expired       = 1'b0;
`endif

  // Alignment FSM. BITSLIP is asserted on the CHECK->SLIP edge so it is high
  // for exactly the single cycle spent in SLIP. DONE/ERR are set on entry
  // to LOCKED/FAIL and cleared on every exit path.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      state          <= IDLE;
      slip_cnt       <= '0;
      settle_cnt     <= '0;
      BITSLIP        <= 1'b0;
      WORD_ALGN_DONE <= 1'b0;
      WORD_ALGN_ERR  <= 1'b0;
    end else begin
      BITSLIP <= 1'b0;
      if (WORD_ALGN_RSTRT || (!PLL_LOCK && state != IDLE)) begin
        state          <= IDLE;
        slip_cnt       <= '0;
        settle_cnt     <= '0;
        WORD_ALGN_DONE <= 1'b0;
        WORD_ALGN_ERR  <= 1'b0;
      end else if (bad_drop) begin
        state          <= WAIT_BIT;
        slip_cnt       <= '0;
        settle_cnt     <= '0;
        WORD_ALGN_DONE <= 1'b0;
        WORD_ALGN_ERR  <= 1'b0;
      end else if (wdog_expired) begin
        state          <= FAIL;
        WORD_ALGN_DONE <= 1'b0;
        WORD_ALGN_ERR  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (PLL_LOCK) state <= WAIT_BIT;
          end
          WAIT_BIT: begin
            if (BIT_ALGN_ERR) begin
              state         <= FAIL;
              WORD_ALGN_ERR <= 1'b1;
            end else if (BIT_ALGN_DONE) begin
              state      <= SETTLE;
              settle_cnt <= '0;
            end
          end
          SETTLE: begin
            if (settle_cnt == STW'(SETTLE_CYCLES - 1)) begin
              state <= CHECK;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          CHECK: begin
            if (match_done) begin
              state          <= LOCKED;
              WORD_ALGN_DONE <= 1'b1;
            end else if (mismatch) begin
              state    <= SLIP;
              BITSLIP  <= 1'b1;
              slip_cnt <= slip_cnt + 1'b1;
            end
          end
          SLIP: begin
            // Every phase of the word has been tried without a lock.
            if (slip_cnt == SCW'(DATA_WIDTH)) begin
              state         <= FAIL;
              WORD_ALGN_ERR <= 1'b1;
            end else begin
              state      <= SETTLE;
              settle_cnt <= '0;
            end
          end
          LOCKED, FAIL: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign SLIP_POS = slip_cnt[SPW-1:0];

  // Valid is the lock state one cycle late; a restart suppresses it at once
  // so every status output is clean the cycle after the pulse.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      RX_WORD_OUT   <= '0;
      RX_WORD_VALID <= 1'b0;
    end else begin
      RX_WORD_OUT   <= RX_DATA;
      RX_WORD_VALID <= (state == LOCKED) && !WORD_ALGN_RSTRT;
    end
  end

endmodule

// File: tb/tb_rx_word_align.sv
module tb_rx_word_align;

  localparam int         DW  = 8;
  localparam logic [7:0] PAT = 8'hB8;

  logic       SCLK = 1'b0;
  logic       RESETN, PLL_LOCK, BIT_ALGN_DONE, BIT_ALGN_ERR, WORD_ALGN_RSTRT;
  logic [7:0] RX_DATA;
  logic       BITSLIP, WORD_ALGN_DONE, WORD_ALGN_ERR, RX_WORD_VALID;
  logic [2:0] SLIP_POS;
  logic [7:0] RX_WORD_OUT;

  always #5 SCLK = ~SCLK;

  rx_word_align #(
    .DATA_WIDTH(DW), .TRAIN_PATTERN(PAT), .MATCH_CNT(16),
    .SETTLE_CYCLES(4), .TIMEOUT_WIDTH(16)
  ) dut (
    .SCLK(SCLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK),
    .BIT_ALGN_DONE(BIT_ALGN_DONE), .BIT_ALGN_ERR(BIT_ALGN_ERR),
    .RX_DATA(RX_DATA), .WORD_ALGN_RSTRT(WORD_ALGN_RSTRT),
    .BITSLIP(BITSLIP), .WORD_ALGN_DONE(WORD_ALGN_DONE), .WORD_ALGN_ERR(WORD_ALGN_ERR),
    .SLIP_POS(SLIP_POS), .RX_WORD_OUT(RX_WORD_OUT), .RX_WORD_VALID(RX_WORD_VALID)
  );

`ifdef WORD_ALIGN_TIMEOUT_EN
  logic       wd_rstn = 1'b0;
  logic       wd_slip, wd_done, wd_err, wd_vld;
  logic [2:0] wd_pos;
  logic [7:0] wd_word;
  rx_word_align #(.DATA_WIDTH(DW), .TRAIN_PATTERN(PAT), .TIMEOUT_WIDTH(4)) dut_wd (
    .SCLK(SCLK), .RESETN(wd_rstn), .PLL_LOCK(1'b1),
    .BIT_ALGN_DONE(1'b0), .BIT_ALGN_ERR(1'b0),
    .RX_DATA(RX_DATA), .WORD_ALGN_RSTRT(1'b0),
    .BITSLIP(wd_slip), .WORD_ALGN_DONE(wd_done), .WORD_ALGN_ERR(wd_err),
    .SLIP_POS(wd_pos), .RX_WORD_OUT(wd_word), .RX_WORD_VALID(wd_vld)
  );
`endif

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];
  int         slips_seen;
  bit         slip_prev;
  bit         zero_mode;
  int         rot;

  typedef struct {
    int rot;
    bit zero;
    int exp_slips;
    bit exp_done;
    bit exp_err;
    int exp_pos;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: sample at the falling edge, score the data path, watch
  // BITSLIP, then model the IOD (each slip rotates the word one bit back).
  task automatic tick();
    @(negedge SCLK);
    if (RESETN && sb_q.size() > 0) check("rx_word_out", RX_WORD_OUT, sb_q.pop_front());
    if (BITSLIP) begin
      check("bitslip_width", slip_prev, 0);
      slips_seen++;
    end
    slip_prev = BITSLIP;
    RX_DATA = zero_mode ? 8'h00 : rotl8(PAT, (rot + 8 * DW - slips_seen) % 8);
    if (RESETN) sb_q.push_back(RX_DATA);
  endtask

  task automatic start(input int r, input bit z);
    rot = r; zero_mode = z;
    RESETN = 1'b0; PLL_LOCK = 1'b0; BIT_ALGN_DONE = 1'b0;
    BIT_ALGN_ERR = 1'b0; WORD_ALGN_RSTRT = 1'b0;
    sb_q.delete(); slips_seen = 0; slip_prev = 1'b0;
    repeat (2) tick();
    RESETN = 1'b1; PLL_LOCK = 1'b1; BIT_ALGN_DONE = 1'b1;
  endtask

  task automatic wait_end(input int budget, output int cyc);
    cyc = 0;
    while (!(WORD_ALGN_DONE || WORD_ALGN_ERR) && cyc < budget) begin
      tick();
      cyc++;
    end
    check("end_state_reached", WORD_ALGN_DONE | WORD_ALGN_ERR, 1);
  endtask

  task automatic wait_slip(input int budget);
    int c;
    c = 0;
    while (!BITSLIP && c < budget) begin
      tick();
      c++;
    end
    check("bitslip_seen", BITSLIP, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, pos_left;

    vecs[0] = '{rot: 0, zero: 0, exp_slips: 0, exp_done: 1, exp_err: 0, exp_pos: 0};
    vecs[1] = '{rot: 3, zero: 0, exp_slips: 3, exp_done: 1, exp_err: 0, exp_pos: 3};
    vecs[2] = '{rot: 5, zero: 0, exp_slips: 5, exp_done: 1, exp_err: 0, exp_pos: 5};
    vecs[3] = '{rot: 7, zero: 0, exp_slips: 7, exp_done: 1, exp_err: 0, exp_pos: 7};
    vecs[4] = '{rot: 0, zero: 1, exp_slips: 8, exp_done: 0, exp_err: 1, exp_pos: 0};

    // Reset values while reset is held.
    start(0, 0);
    RESETN = 1'b0;
    tick();
    check("rst_bitslip", BITSLIP, 0);
    check("rst_done", WORD_ALGN_DONE, 0);
    check("rst_err", WORD_ALGN_ERR, 0);
    check("rst_slip_pos", SLIP_POS, 0);
    check("rst_word_out", RX_WORD_OUT, 0);
    check("rst_valid", RX_WORD_VALID, 0);

    // Table: rotated training word, and all-zero data that never locks.
    for (int i = 0; i < 5; i++) begin
      start(vecs[i].rot, vecs[i].zero);
      wait_end(600, cyc);
      if (vecs[i].rot == 0 && !vecs[i].zero)
        check("lock_latency_in_range", (cyc >= 20 && cyc <= 26), 1);
      check("done", WORD_ALGN_DONE, vecs[i].exp_done);
      check("err", WORD_ALGN_ERR, vecs[i].exp_err);
      check("slip_pulses", slips_seen, vecs[i].exp_slips);
      check("slip_pos", SLIP_POS, vecs[i].exp_pos);
      repeat (3) tick();
      check("done_held", WORD_ALGN_DONE, vecs[i].exp_done);
      check("err_held", WORD_ALGN_ERR, vecs[i].exp_err);
      check("valid", RX_WORD_VALID, vecs[i].exp_done);
      check("no_extra_slips", slips_seen, vecs[i].exp_slips);
      check("done_err_exclusive", WORD_ALGN_DONE & WORD_ALGN_ERR, 0);
    end

    // Bit alignment lost while locked, then regained.
    start(0, 0);
    wait_end(100, cyc);
    BIT_ALGN_DONE = 1'b0;
    repeat (2) tick();
    check("drop_done", WORD_ALGN_DONE, 0);
    check("drop_valid", RX_WORD_VALID, 0);
    check("drop_err", WORD_ALGN_ERR, 0);
    BIT_ALGN_DONE = 1'b1;
    wait_end(100, cyc);
    check("relock_done", WORD_ALGN_DONE, 1);
    check("relock_slip_pos", SLIP_POS, 0);

    // Restart in the same cycle as a BITSLIP pulse; the IOD keeps the slip,
    // so only the remaining slips are counted after realignment.
    start(3, 0);
    wait_slip(100);
    WORD_ALGN_RSTRT = 1'b1;
    tick();
    WORD_ALGN_RSTRT = 1'b0;
    check("rstrt_slip_bitslip", BITSLIP, 0);
    check("rstrt_slip_pos", SLIP_POS, 0);
    check("rstrt_slip_done", WORD_ALGN_DONE, 0);
    check("rstrt_slip_err", WORD_ALGN_ERR, 0);
    pos_left = 3 - slips_seen;
    wait_end(300, cyc);
    check("rstrt_relock_done", WORD_ALGN_DONE, 1);
    check("rstrt_relock_pos", SLIP_POS, pos_left);

    // Restart as lock is reached.
    start(0, 0);
    wait_end(100, cyc);
    WORD_ALGN_RSTRT = 1'b1;
    tick();
    WORD_ALGN_RSTRT = 1'b0;
    check("rstrt_lock_done", WORD_ALGN_DONE, 0);
    check("rstrt_lock_valid", RX_WORD_VALID, 0);
    check("rstrt_lock_err", WORD_ALGN_ERR, 0);

    // PLL lock lost while locked.
    start(0, 0);
    wait_end(100, cyc);
    PLL_LOCK = 1'b0;
    tick();
    check("pll_drop_done", WORD_ALGN_DONE, 0);
    tick();
    check("pll_drop_valid", RX_WORD_VALID, 0);
    PLL_LOCK = 1'b1;
    wait_end(100, cyc);
    check("pll_relock_done", WORD_ALGN_DONE, 1);

    // Bit aligner reports an error: terminal FAIL until restart.
    start(0, 0);
    BIT_ALGN_DONE = 1'b0;
    BIT_ALGN_ERR  = 1'b1;
    wait_end(20, cyc);
    check("bit_err_err", WORD_ALGN_ERR, 1);
    check("bit_err_done", WORD_ALGN_DONE, 0);
    check("bit_err_slips", slips_seen, 0);
    WORD_ALGN_RSTRT = 1'b1;
    tick();
    WORD_ALGN_RSTRT = 1'b0;
    check("bit_err_cleared", WORD_ALGN_ERR, 0);

    // Asynchronous reset in the middle of a slip pulse.
    start(5, 0);
    wait_slip(100);
    #2;
    RESETN = 1'b0;
    #1;
    check("async_rst_bitslip", BITSLIP, 0);
    check("async_rst_slip_pos", SLIP_POS, 0);
    sb_q.delete();

    // Waiting for bit alignment with no watchdog pressure on the main DUT.
    start(0, 0);
    BIT_ALGN_DONE = 1'b0;
    repeat (40) tick();
    check("wait_bit_no_err", WORD_ALGN_ERR, 0);
    check("wait_bit_no_done", WORD_ALGN_DONE, 0);

`ifdef WORD_ALIGN_TIMEOUT_EN
    wd_rstn = 1'b1;
    repeat (15) tick();
    check("wdog_not_yet", wd_err, 0);
    tick();
    check("wdog_fired", wd_err, 1);
    check("wdog_done_low", wd_done, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_word_align.md
RX_WORD_ALIGN -- requirements
Module: rx_word_align

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, deserialised lane word width in bits.
REQ-002 SHALL provide parameter TRAIN_PATTERN, default 8'hB8, expected training word (DATA_WIDTH bits).
REQ-003 SHALL provide parameter MATCH_CNT, default 16, consecutive matches required to declare lock.
REQ-004 SHALL provide parameter SETTLE_CYCLES, default 4, cycles ignored after each slip.
REQ-005 SHALL provide parameter TIMEOUT_WIDTH, default 16, watchdog counter width.
REQ-006 SHALL provide ports: SCLK in 1 lane clock; RESETN in 1 active-low reset.
REQ-007 SHALL provide ports: PLL_LOCK in 1; BIT_ALGN_DONE in 1; BIT_ALGN_ERR in 1.
REQ-008 SHALL provide ports: RX_DATA in DATA_WIDTH deserialiser word; WORD_ALGN_RSTRT in 1 restart pulse.
REQ-009 SHALL provide ports: BITSLIP out 1 slip pulse to IOD; WORD_ALGN_DONE out 1; WORD_ALGN_ERR out 1.
REQ-010 SHALL provide ports: SLIP_POS out clog2(DATA_WIDTH) slips applied; RX_WORD_OUT out DATA_WIDTH; RX_WORD_VALID out 1.
REQ-011 SHALL use one clock, SCLK; reset RESETN is asynchronous and active-low.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_BIT, SETTLE, CHECK, SLIP, LOCKED, FAIL.
REQ-013 IDLE -> WAIT_BIT when PLL_LOCK=1.
REQ-014 WAIT_BIT -> SETTLE when BIT_ALGN_DONE=1 and BIT_ALGN_ERR=0; -> FAIL when BIT_ALGN_ERR=1.
REQ-015 SETTLE counts SETTLE_CYCLES cycles, ignores RX_DATA, then -> CHECK.
REQ-016 CHECK: RX_DATA==TRAIN_PATTERN increments match counter; reaching MATCH_CNT -> LOCKED; any mismatch clears counter and -> SLIP.
REQ-017 SLIP: BITSLIP high exactly one cycle, slip counter +1; if new count equals DATA_WIDTH -> FAIL, else -> SETTLE.
REQ-018 LOCKED: WORD_ALGN_DONE=1, SLIP_POS holds final slip count; FAIL: WORD_ALGN_ERR=1; both terminal until restart.
REQ-019 BIT_ALGN_DONE falling in SETTLE/CHECK/SLIP/LOCKED SHALL return FSM to WAIT_BIT, clear counters, drop WORD_ALGN_DONE next cycle.
REQ-020 WORD_ALGN_RSTRT=1 SHALL force IDLE from any state next cycle, clearing all counters; highest priority over all transitions.
REQ-021 PLL_LOCK=0 in any non-IDLE state SHALL force IDLE (priority below restart).
REQ-022 RX_WORD_OUT SHALL be RX_DATA registered, 1-cycle latency; RX_WORD_VALID = registered (state==LOCKED).
REQ-023 WORD_ALGN_DONE and WORD_ALGN_ERR SHALL never be high together.

Reset
REQ-024 On RESETN=0: state IDLE; BITSLIP, WORD_ALGN_DONE, WORD_ALGN_ERR, RX_WORD_VALID = 0; SLIP_POS, RX_WORD_OUT, all counters = 0.
REQ-025 Reset mid-slip SHALL drop BITSLIP immediately (asynchronous).

Configuration
REQ-026 Macro WORD_ALIGN_TIMEOUT_EN defined: TIMEOUT_WIDTH-bit watchdog counts cycles in WAIT_BIT/SETTLE/CHECK/SLIP, cleared on entry to WAIT_BIT or on lock; saturation at all-ones -> FAIL.
REQ-027 Macro undefined: no watchdog logic; FSM waits indefinitely in WAIT_BIT and CHECK loops.

Structure
REQ-028 Shared package SHALL hold FSM state enum and default TRAIN_PATTERN/MATCH_CNT/SETTLE_CYCLES constants.
REQ-029 One sub-module rx_word_align_cmp: registered pattern compare plus consecutive-match counter, outputs match_done and mismatch.

Verification
REQ-030 Reset, PLL_LOCK=1, BIT_ALGN_DONE=1, RX_DATA=8'hB8 constant -> BITSLIP never pulses, WORD_ALGN_DONE after SETTLE+16 cycles, SLIP_POS=0.
REQ-031 Bench rotates 8'hB8 by 3 bits, each BITSLIP rotates by 1 -> exactly 3 BITSLIP pulses, each 1 cycle, LOCKED, SLIP_POS=3.
REQ-032 RX_DATA=8'h00 always -> 8 BITSLIP pulses then WORD_ALGN_ERR=1, WORD_ALGN_DONE=0.
REQ-033 Locked, then BIT_ALGN_DONE falls -> WORD_ALGN_DONE=0 and RX_WORD_VALID=0 within 2 cycles, FSM relocks after BIT_ALGN_DONE returns.
REQ-034 WORD_ALGN_RSTRT pulse in same cycle as BITSLIP/lock event -> IDLE next cycle, all outputs reset values.
REQ-035 With WORD_ALIGN_TIMEOUT_EN, TIMEOUT_WIDTH=4, BIT_ALGN_DONE held 0 -> WORD_ALGN_ERR=1 after 15 cycles in WAIT_BIT; without macro -> no error.
